// File: rtl/inst_queue_frontend_pkg.sv
// Shared encodings for the instruction front end: branch nibble and long-instruction predicate.
// A long instruction has a non-branch top nibble, a zero imm6[5:2] field and imm6[0] set.
package inst_queue_frontend_pkg;

    localparam logic [3:0] BRANCH_NIBBLE = 4'b0000;

    function automatic logic is_long_inst(input logic [15:0] w);
        return (w[15:12] != BRANCH_NIBBLE) && (w[5:2] == 4'b0000) && w[0];
    endfunction

endpackage

// File: rtl/inst_queue_frontend_if.sv
// Prefetch chunk stream in, decoder instruction/imm16 handoff out.
// master drives the stream and decoder controls; slave is the front end.
interface inst_queue_frontend_if #(
    parameter int NSHIFT    = 2,
    parameter int WORD_BITS = 16,
    parameter int DEPTH     = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic [NSHIFT-1:0]    in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 flush;
    logic                 inst_valid;
    logic [WORD_BITS-1:0] inst;
    logic [WORD_BITS-1:0] imm16;
    logic                 inst_long;
    logic                 inst_done;
    logic [LW-1:0]        level;

    modport master (
        output in_data, in_valid, flush, inst_done,
        input  in_ready, inst_valid, inst, imm16, inst_long, level
    );

    modport slave (
        input  in_data, in_valid, flush, inst_done,
        output in_ready, inst_valid, inst, imm16, inst_long, level
    );
endinterface

// File: rtl/inst_queue_frontend_chunk_assembler.sv
// Packs NSHIFT-bit chunks LSB-first into a word; word_vld/word_dat are combinational on the final chunk.
// No backpressure of its own: the caller only raises chunk_vld for chunks it has accepted.
module inst_queue_frontend_chunk_assembler #(
    parameter int NSHIFT    = 2,
    parameter int WORD_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 chunk_vld,
    input  logic [NSHIFT-1:0]    chunk_dat,
    output logic                 word_vld,
    output logic [WORD_BITS-1:0] word_dat
);
    localparam int NCHUNK = WORD_BITS / NSHIFT;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WORD_BITS-1:0] asm_q, asm_d;

    always_comb begin
        word_dat = asm_q;
        word_dat[NSHIFT*cnt_q +: NSHIFT] = chunk_dat;
        word_vld = chunk_vld && (cnt_q == CW'(NCHUNK - 1));
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        if (clear) begin
            cnt_d = '0;
        end else if (chunk_vld) begin
            asm_d = word_dat;
            cnt_d = word_vld ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
        end
    end
endmodule

// File: rtl/inst_queue_frontend.sv
// Chunk assembler + DEPTH-word FIFO presenting instruction/imm16 pairs; 1 cycle word latency
// (0 with INST_QUEUE_FRONTEND_BYPASS_EN into an empty queue); in_ready drops only while full.
module inst_queue_frontend
    import inst_queue_frontend_pkg::*;
#(
    parameter int NSHIFT    = 2,
    parameter int WORD_BITS = 16,
    parameter int DEPTH     = 4
) (
    input logic                   clk,
    input logic                   reset,
    inst_queue_frontend_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WORD_BITS-1:0] mem_q [DEPTH];
    logic [WORD_BITS-1:0] mem_d [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d, pop_n;

    logic                 chunk_acc, word_vld, push;
    logic [WORD_BITS-1:0] word_dat, head, next_w;
    logic                 head_long, fifo_vld, pop_fifo;
    logic                 byp_act, byp_long, byp_take;

    assign bus.in_ready = (level_q < LW'(DEPTH));
    assign bus.level    = level_q;
    // A flushed cycle must not advance the partial word either.
    assign chunk_acc    = bus.in_valid && bus.in_ready && !bus.flush;

    inst_queue_frontend_chunk_assembler #(
        .NSHIFT    (NSHIFT),
        .WORD_BITS (WORD_BITS)
    ) u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (bus.flush),
        .chunk_vld (chunk_acc),
        .chunk_dat (bus.in_data),
        .word_vld  (word_vld),
        .word_dat  (word_dat)
    );

    assign head      = mem_q[rd_ptr_q];
    assign next_w    = mem_q[rd_ptr_q + PW'(1)];
    assign head_long = (level_q != '0) && is_long_inst(head[15:0]);
    assign fifo_vld  = (level_q != '0) && (!head_long || level_q >= LW'(2));
    assign pop_fifo  = bus.inst_done && fifo_vld && !bus.flush;
    assign pop_n     = pop_fifo ? (head_long ? LW'(2) : LW'(1)) : LW'(0);

`ifdef INST_QUEUE_FRONTEND_BYPASS_EN
    assign byp_act  = (level_q == '0) && word_vld;
    assign byp_long = is_long_inst(word_dat[15:0]);
    assign byp_take = byp_act && !byp_long && bus.inst_done;
`else
    assign byp_act  = 1'b0;
    assign byp_long = 1'b0;
    assign byp_take = 1'b0;
`endif

    // A bypassed word consumed by the decoder never enters the FIFO.
    assign push = word_vld && !byp_take;

    always_comb begin
        bus.inst_valid = fifo_vld;
        bus.inst       = (level_q != '0) ? head : '0;
        bus.inst_long  = head_long;
        bus.imm16      = head_long ? next_w : '0;
        if (byp_act) begin
            bus.inst_valid = !byp_long;
            bus.inst       = word_dat;
            bus.inst_long  = byp_long;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = word_dat;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            rd_ptr_d = rd_ptr_q + PW'(pop_n);
            level_d  = level_q + LW'(push) - pop_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (level_q <= LW'(DEPTH));
            assert (pop_n <= level_q);
        end
    end
endmodule

// File: tb/tb_inst_queue_frontend.sv
// Directed bench for inst_queue_frontend with a queue-based reference model checked every cycle.
module tb_inst_queue_frontend;
    localparam int NSHIFT = 2;
    localparam int WB     = 16;
    localparam int DEPTH  = 4;
    localparam int NCH    = WB / NSHIFT;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inst_queue_frontend_if #(.NSHIFT(NSHIFT), .WORD_BITS(WB), .DEPTH(DEPTH)) bus();

    inst_queue_frontend #(.NSHIFT(NSHIFT), .WORD_BITS(WB), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] m_q[$];
    int          m_cnt = 0;
    logic [15:0] m_asm = '0;

    function automatic logic spec_long(input logic [15:0] w);
        return (w[15:12] != 4'b0000) && (w[5:2] == 4'b0000) && w[0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words queue in arrival order and leave one or two at a time.
    always @(posedge clk or negedge reset) begin : model
        logic        fin;
        logic        consumed;
        logic [15:0] w;
        if (!reset) begin
            m_q.delete();
            m_cnt = 0;
        end else if (bus.flush) begin
            m_q.delete();
            m_cnt = 0;
        end else begin
            fin      = 1'b0;
            consumed = 1'b0;
            w        = m_asm;
            if (bus.in_valid && m_q.size() < DEPTH) begin
                w[2*m_cnt +: 2] = bus.in_data;
                m_asm = w;
                fin   = (m_cnt == NCH - 1);
                m_cnt = fin ? 0 : m_cnt + 1;
            end
            if (m_q.size() >= 1) begin
                if (bus.inst_done && (!spec_long(m_q[0]) || m_q.size() >= 2)) begin
                    if (spec_long(m_q[0])) void'(m_q.pop_front());
                    void'(m_q.pop_front());
                end
            end
`ifdef INST_QUEUE_FRONTEND_BYPASS_EN
            else if (fin && !spec_long(w) && bus.inst_done) begin
                consumed = 1'b1;
            end
`endif
            if (fin && !consumed) m_q.push_back(w);
        end
    end

    always @(negedge clk) begin : cmp
        logic [15:0] e_inst, e_imm, w;
        logic        e_vld, e_long;
        int          e_lvl;
        e_lvl  = m_q.size();
        e_vld  = 1'b0;
        e_long = 1'b0;
        e_inst = '0;
        e_imm  = '0;
        w      = m_asm;
        if (e_lvl >= 1) begin
            e_inst = m_q[0];
            e_long = spec_long(m_q[0]);
            e_vld  = !e_long || e_lvl >= 2;
            if (e_long && e_lvl >= 2) e_imm = m_q[1];
        end
`ifdef INST_QUEUE_FRONTEND_BYPASS_EN
        else if (reset && bus.in_valid && !bus.flush && m_cnt == NCH - 1) begin
            w[2*m_cnt +: 2] = bus.in_data;
            e_inst = w;
            e_long = spec_long(w);
            e_vld  = !e_long;
        end
`endif
        chk("cyc_in_ready", bus.in_ready, e_lvl < DEPTH);
        chk("cyc_level", bus.level, e_lvl);
        chk("cyc_inst_valid", bus.inst_valid, e_vld);
        chk("cyc_inst", bus.inst, e_inst);
        chk("cyc_inst_long", bus.inst_long, e_long);
        if (e_vld) chk("cyc_imm16", bus.imm16, e_imm);
    end

    task automatic push_word(input logic [15:0] w, input logic done_last);
        for (int k = 0; k < NCH; k++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = w[2*k +: 2];
            bus.inst_done = done_last && (k == NCH - 1);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.inst_done = 1'b0;
    endtask

    task automatic pop_one();
        bus.inst_done = 1'b1;
        @(posedge clk); #1;
        bus.inst_done = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.inst_done = 1'b0;
        #12;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_inst_valid", bus.inst_valid, 0);
        chk("rst_inst", bus.inst, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_imm16", bus.imm16, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        push_word(16'h8123, 1'b0);
        chk("short_valid", bus.inst_valid, 1);
        chk("short_inst", bus.inst, 16'h8123);
        chk("short_long", bus.inst_long, 0);
        chk("short_imm16", bus.imm16, 0);
        chk("short_level", bus.level, 1);
        pop_one();
        chk("short_pop_level", bus.level, 0);

        push_word(16'h2001, 1'b0);
        chk("long_half_valid", bus.inst_valid, 0);
        chk("long_half_long", bus.inst_long, 1);
        push_word(16'hBEEF, 1'b0);
        chk("long_valid", bus.inst_valid, 1);
        chk("long_inst", bus.inst, 16'h2001);
        chk("long_imm16", bus.imm16, 16'hBEEF);
        chk("long_level", bus.level, 2);
        pop_one();
        chk("long_pop_level", bus.level, 0);

        push_word(16'h0401, 1'b0);
        chk("branch_long", bus.inst_long, 0);
        chk("branch_valid", bus.inst_valid, 1);
        pop_one();

        push_word(16'h8123, 1'b0);
        push_word(16'h1234, 1'b0);
        push_word(16'h5678, 1'b0);
        push_word(16'h9ABC, 1'b0);
        chk("full_level", bus.level, 4);
        chk("full_in_ready", bus.in_ready, 0);
        pop_one();
        chk("pop_full_level", bus.level, 3);
        chk("pop_full_in_ready", bus.in_ready, 1);
        chk("pop_full_inst", bus.inst, 16'h1234);
        push_word(16'h4321, 1'b1);
        chk("pushpop_level", bus.level, 3);
        chk("pushpop_inst", bus.inst, 16'h5678);

        pop_one();
        w = 16'hFACE;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[2*k +: 2];
            @(posedge clk); #1;
        end
        bus.in_data   = 2'b11;
        bus.flush     = 1'b1;
        bus.inst_done = 1'b1;
        @(posedge clk); #1;
        bus.flush     = 1'b0;
        bus.inst_done = 1'b0;
        bus.in_valid  = 1'b0;
        chk("flush_level", bus.level, 0);
        chk("flush_valid", bus.inst_valid, 0);
        push_word(16'h1357, 1'b0);
        chk("post_flush_inst", bus.inst, 16'h1357);
        chk("post_flush_level", bus.level, 1);
        pop_one();

        push_word(16'h8123, 1'b0);
        w = 16'h2468;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[2*k +: 2];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_level", bus.level, 0);
        chk("arst_valid", bus.inst_valid, 0);
        chk("arst_inst", bus.inst, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        push_word(16'h8123, 1'b0);
        chk("post_arst_inst", bus.inst, 16'h8123);
        pop_one();

        w = 16'h1357;
        for (int k = 0; k < NCH - 1; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = w[2*k +: 2];
            @(posedge clk); #1;
        end
        bus.in_data   = w[2*(NCH-1) +: 2];
        bus.inst_done = 1'b1;
        #1;
`ifdef INST_QUEUE_FRONTEND_BYPASS_EN
        chk("byp_valid", bus.inst_valid, 1);
        chk("byp_inst", bus.inst, 16'h1357);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.inst_done = 1'b0;
        chk("byp_level", bus.level, 0);
`else
        chk("nobyp_valid", bus.inst_valid, 0);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.inst_done = 1'b0;
        chk("nobyp_level", bus.level, 1);
        chk("nobyp_inst", bus.inst, 16'h1357);
        pop_one();
`endif
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
